// File: rtl/bp_common_pkg.sv
// bp_common_pkg: shared TLB entry layout, FSM states and entry width helper
package bp_common_pkg;
  localparam int ptag_width_gp = 28;
  localparam int levels_gp = 3;
  localparam int lg_levels_gp = $clog2(levels_gp);
  typedef struct packed {
    logic [ptag_width_gp-1:0] ptag;
    logic [lg_levels_gp-1:0] level;
    logic g, u, x, w, r, a, d;
  } bp_tlb_entry_s;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} tlb_state_e;
  function automatic int tlb_entry_width(int ptag_width, int levels);
    return ptag_width + $clog2(levels) + 7;
  endfunction
endpackage

// File: rtl/bp_tlb_asid_if.sv
// bp_tlb_asid_if: lookup, miss, fill and flush signals between the address path/PTW and the TLB
interface bp_tlb_asid_if
  import bp_common_pkg::*;
#(
  parameter int vtag_width_p = 27,
  parameter int asid_width_p = 9,
  parameter int entry_width_p = tlb_entry_width(ptag_width_gp, levels_gp)
);
  logic translation_en;
  logic [asid_width_p-1:0] asid;
  logic r_v, r_ready, v;
  logic [vtag_width_p-1:0] r_vtag;
  logic [entry_width_p-1:0] entry;
  logic miss_v, miss_ready;
  logic [vtag_width_p-1:0] miss_vtag;
  logic fill_v;
  logic [entry_width_p-1:0] fill_entry;
  logic flush_v, flush_asid_v, flush_vtag_v;
  logic [asid_width_p-1:0] flush_asid;
  logic [vtag_width_p-1:0] flush_vtag;
  modport master (
    output translation_en, asid, r_v, r_vtag, miss_ready, fill_v, fill_entry,
           flush_v, flush_asid_v, flush_vtag_v, flush_asid, flush_vtag,
    input r_ready, v, entry, miss_v, miss_vtag
  );
  modport slave (
    input translation_en, asid, r_v, r_vtag, miss_ready, fill_v, fill_entry,
          flush_v, flush_asid_v, flush_vtag_v, flush_asid, flush_vtag,
    output r_ready, v, entry, miss_v, miss_vtag
  );
endinterface

// File: rtl/bp_tlb_asid_match.sv
// bp_tlb_asid_match: level-masked vtag compare and ASID compare for one entry
module bp_tlb_asid_match #(
  parameter int vtag_width_p = 27,
  parameter int asid_width_p = 9,
  parameter int lvl_width_p = 9,
  parameter int lg_levels_lp = 2
)(
  input  logic [vtag_width_p-1:0] entry_vtag,
  input  logic [asid_width_p-1:0] entry_asid,
  input  logic [lg_levels_lp-1:0] level,
  input  logic [vtag_width_p-1:0] key_vtag,
  input  logic [asid_width_p-1:0] key_asid,
  output logic vtag_match,
  output logic asid_match
);
  logic [vtag_width_p-1:0] mask;
  assign mask = {vtag_width_p{1'b1}} << (32'(level) * lvl_width_p);
  assign vtag_match = ((entry_vtag ^ key_vtag) & mask) == '0;
  assign asid_match = entry_asid == key_asid;
endmodule

// File: rtl/bp_tlb_asid.sv
// bp_tlb_asid: fully-associative ASID-tagged superpage TLB with PTW miss handshake and selective flush
module bp_tlb_asid
  import bp_common_pkg::*;
#(
  parameter int els_p = 8,
  parameter int vtag_width_p = 27,
  parameter int ptag_width_p = ptag_width_gp,
  parameter int asid_width_p = 9,
  parameter int levels_p = levels_gp,
  parameter int lvl_width_p = 9,
  localparam int lg_els_lp = $clog2(els_p),
  localparam int lg_levels_lp = $clog2(levels_p)
)(
  input logic clk_i,
  input logic reset_n_i,
  bp_tlb_asid_if.slave bus
);
  typedef struct packed {
    logic [ptag_width_p-1:0] ptag;
    logic [lg_levels_lp-1:0] level;
    logic g, u, x, w, r, a, d;
  } entry_s;
  tlb_state_e state_r, state_n;
  logic stale_r, stale_n, stale_eff, accept, miss, write, use_ptr, v_r;
  logic [els_p-1:0] valid_r, live, hit_vec, dup, kill, lk_v, lk_a, fd_v, fd_a, fl_v, fl_a;
  entry_s ent_r [els_p];
  logic [vtag_width_p-1:0] vtag_r [els_p];
  logic [asid_width_p-1:0] asid_r [els_p];
  logic [lg_els_lp-1:0] ptr_r, tgt, dup_idx, inv_idx;
  logic [vtag_width_p-1:0] miss_vtag_r;
  logic [asid_width_p-1:0] miss_asid_r;
  logic [ptag_width_p-1:0] pmask;
  entry_s entry_r, fill_e, hit_e, res_e;
  assign fill_e = entry_s'(bus.fill_entry);
  for (genvar k = 0; k < els_p; k++) begin : g_ent
    bp_tlb_asid_match #(.vtag_width_p(vtag_width_p), .asid_width_p(asid_width_p),
      .lvl_width_p(lvl_width_p), .lg_levels_lp(lg_levels_lp)) u_lk (
      .entry_vtag(vtag_r[k]), .entry_asid(asid_r[k]), .level(ent_r[k].level),
      .key_vtag(bus.r_vtag), .key_asid(bus.asid), .vtag_match(lk_v[k]), .asid_match(lk_a[k]));
    bp_tlb_asid_match #(.vtag_width_p(vtag_width_p), .asid_width_p(asid_width_p),
      .lvl_width_p(lvl_width_p), .lg_levels_lp(lg_levels_lp)) u_fd (
      .entry_vtag(vtag_r[k]), .entry_asid(asid_r[k]), .level(ent_r[k].level),
      .key_vtag(miss_vtag_r), .key_asid(miss_asid_r), .vtag_match(fd_v[k]), .asid_match(fd_a[k]));
    bp_tlb_asid_match #(.vtag_width_p(vtag_width_p), .asid_width_p(asid_width_p),
      .lvl_width_p(lvl_width_p), .lg_levels_lp(lg_levels_lp)) u_fl (
      .entry_vtag(vtag_r[k]), .entry_asid(asid_r[k]), .level(ent_r[k].level),
      .key_vtag(bus.flush_vtag), .key_asid(bus.flush_asid), .vtag_match(fl_v[k]), .asid_match(fl_a[k]));
    assign hit_vec[k] = valid_r[k] & (ent_r[k].g | lk_a[k]) & lk_v[k];
    assign kill[k] = bus.flush_v & (~bus.flush_asid_v | (fl_a[k] & ~ent_r[k].g))
                     & (~bus.flush_vtag_v | fl_v[k]);
    assign dup[k] = live[k] & fd_v[k] & fd_a[k] & (ent_r[k].level == fill_e.level);
  end
  // fill sees post-flush contents; lookup sees pre-flush contents
  assign live = valid_r & ~kill;
  always_comb begin
    hit_e = '0;
    dup_idx = '0;
    inv_idx = '0;
    for (int k = els_p - 1; k >= 0; k--) begin
      if (hit_vec[k]) hit_e = ent_r[k];
      if (dup[k]) dup_idx = lg_els_lp'(k);
      if (!live[k]) inv_idx = lg_els_lp'(k);
    end
    use_ptr = ~|dup & &live;
    tgt = |dup ? dup_idx : ~&live ? inv_idx : ptr_r;
    pmask = {ptag_width_p{1'b1}} << (32'(hit_e.level) * lvl_width_p);
    res_e = hit_e;
    res_e.ptag = (hit_e.ptag & pmask) | (ptag_width_p'(bus.r_vtag) & ~pmask);
    if (!bus.translation_en) res_e = '{ptag: ptag_width_p'(bus.r_vtag), level: '0, g: 1'b0, default: 1'b1};
  end
  always_comb begin
    accept = bus.r_v & (state_r == IDLE);
    miss = accept & bus.translation_en & ~|hit_vec;
    stale_eff = stale_r | (bus.flush_v & (state_r != IDLE));
    write = bus.fill_v & ~stale_eff;
    stale_n = bus.fill_v ? 1'b0 : stale_eff;
    state_n = state_r == IDLE ? (miss ? REQ : IDLE)
            : state_r == REQ  ? (bus.fill_v & stale_eff ? IDLE : bus.miss_ready ? WAIT : REQ)
            : (bus.fill_v ? IDLE : WAIT);
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r <= IDLE;
      stale_r <= 1'b0;
    end else begin
      state_r <= state_n;
      stale_r <= stale_n;
    end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      valid_r <= '0;
      ptr_r <= '0;
      v_r <= 1'b0;
      entry_r <= '0;
      miss_vtag_r <= '0;
      miss_asid_r <= '0;
    end else begin
      valid_r <= live | (write ? els_p'(1) << tgt : '0);
      ptr_r <= ptr_r + lg_els_lp'(write & use_ptr);
      v_r <= accept & ~miss;
      if (accept & ~miss) entry_r <= res_e;
      if (miss) begin
        miss_vtag_r <= bus.r_vtag;
        miss_asid_r <= bus.asid;
      end
    end
  always_ff @(posedge clk_i)
    if (write) begin
      ent_r[tgt] <= fill_e;
      vtag_r[tgt] <= miss_vtag_r;
      asid_r[tgt] <= miss_asid_r;
    end
  assign bus.r_ready = state_r == IDLE;
  assign bus.v = v_r;
  assign bus.entry = entry_r;
  assign bus.miss_v = state_r == REQ;
  assign bus.miss_vtag = miss_vtag_r;
endmodule

// File: tb/tb_bp_tlb_asid.sv
// tb_bp_tlb_asid: directed scoreboard bench for the ASID TLB
module tb_bp_tlb_asid;
  import bp_common_pkg::*;
  localparam int EW = $bits(bp_tlb_entry_s);
  typedef struct { bit is_miss; logic [EW-1:0] data; } exp_t;
  logic clk = 1'b0, reset_n = 1'b0;
  int errors = 0, checks = 0;
  bit miss_prev = 1'b0;
  exp_t q[$];
  always #5 clk = ~clk;
  bp_tlb_asid_if bus ();
  bp_tlb_asid dut (.clk_i(clk), .reset_n_i(reset_n), .bus(bus));
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  task automatic pop(bit is_miss, logic [EW-1:0] data);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_resp: got miss=%0d data=%0h, required no response", is_miss, data);
    end else begin
      e = q.pop_front();
      check("resp", {is_miss, data}, {e.is_miss, e.data});
    end
  endtask
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.v) pop(1'b0, bus.entry);
      if (bus.miss_v && !miss_prev) pop(1'b1, EW'(bus.miss_vtag));
    end
    miss_prev = bus.miss_v;
  end
  function automatic bp_tlb_entry_s mk(logic [27:0] p, logic [1:0] l, logic g);
    return '{ptag: p, level: l, g: g, default: 1'b1};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic lookup(logic [26:0] t, bit is_miss, logic [EW-1:0] data);
    exp_t e;
    e.is_miss = is_miss;
    e.data = data;
    q.push_back(e);
    bus.r_v = 1'b1;
    bus.r_vtag = t;
    step();
    bus.r_v = 1'b0;
  endtask
  task automatic hit(logic [26:0] t, bp_tlb_entry_s e);
    lookup(t, 1'b0, e);
  endtask
  task automatic miss_fill(logic [26:0] t, bp_tlb_entry_s e);
    lookup(t, 1'b1, EW'(t));
    bus.miss_ready = 1'b1;
    step();
    bus.miss_ready = 1'b0;
    bus.fill_v = 1'b1;
    bus.fill_entry = e;
    step();
    bus.fill_v = 1'b0;
  endtask
  task automatic flush(bit av, bit vv, logic [8:0] a, logic [26:0] t);
    bus.flush_v = 1'b1;
    bus.flush_asid_v = av;
    bus.flush_vtag_v = vv;
    bus.flush_asid = a;
    bus.flush_vtag = t;
    step();
    bus.flush_v = 1'b0;
    bus.flush_asid_v = 1'b0;
    bus.flush_vtag_v = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end
  initial begin
    bus.translation_en = 0; bus.asid = 0; bus.r_v = 0; bus.r_vtag = 0;
    bus.miss_ready = 0; bus.fill_v = 0; bus.fill_entry = 0;
    bus.flush_v = 0; bus.flush_asid_v = 0; bus.flush_vtag_v = 0;
    bus.flush_asid = 0; bus.flush_vtag = 0;
    repeat (2) step();
    check("rst_v", bus.v, 0);
    check("rst_miss_v", bus.miss_v, 0);
    check("rst_entry", bus.entry, 0);
    check("rst_miss_vtag", bus.miss_vtag, 0);
    reset_n = 1'b1;
    step();
    check("rst_ready", bus.r_ready, 1);
    hit(27'h123, mk(28'h123, 0, 0));
    check("pass_no_miss", bus.miss_v, 0);
    bus.translation_en = 1;
    bus.asid = 5;
    lookup(27'h1000, 1'b1, EW'(27'h1000));
    for (int i = 0; i < 3; i++) begin
      check("hold_miss_v", bus.miss_v, 1);
      check("hold_ready", bus.r_ready, 0);
      bus.r_v = (i == 0);
      bus.r_vtag = 27'h55;
      step();
    end
    bus.r_v = 0;
    bus.miss_ready = 1;
    step();
    bus.miss_ready = 0;
    check("hs_drop", bus.miss_v, 0);
    bus.fill_v = 1;
    bus.fill_entry = mk(28'h8000, 0, 0);
    step();
    bus.fill_v = 0;
    check("wait_to_idle", bus.r_ready, 1);
    hit(27'h1000, mk(28'h8000, 0, 0));
    miss_fill(27'h200, mk(28'h40000, 1, 0));
    hit(27'h3FF, mk(28'h401FF, 1, 0));
    bus.asid = 6;
    miss_fill(27'h3FF, mk(28'h40000, 1, 1));
    hit(27'h3FF, mk(28'h401FF, 1, 1));
    bus.asid = 7;
    hit(27'h250, mk(28'h40050, 1, 1));
    bus.asid = 5;
    flush(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) miss_fill(27'h10 + 27'(i), mk(28'h100 + 28'(i), 0, 0));
    hit(27'h18, mk(28'h108, 0, 0));
    hit(27'h19, mk(28'h109, 0, 0));
    hit(27'h13, mk(28'h103, 0, 0));
    miss_fill(27'h10, mk(28'h100, 0, 0));
    hit(27'h10, mk(28'h100, 0, 0));
    miss_fill(27'h12, mk(28'h102, 0, 0));
    miss_fill(27'h13, mk(28'h103, 0, 0));
    for (int j = 0; j < 4; j++) miss_fill(27'h30 + 27'(j), mk(28'h300 + 28'(j), 0, 0));
    miss_fill(27'h18, mk(28'h108, 0, 0));
    miss_fill(27'h19, mk(28'h109, 0, 0));
    hit(27'h33, mk(28'h303, 0, 0));
    hit(27'h12, mk(28'h102, 0, 0));
    flush(0, 0, 0, 0);
    miss_fill(27'h40, mk(28'h500, 0, 0));
    bus.asid = 6;
    miss_fill(27'h41, mk(28'h600, 0, 0));
    miss_fill(27'h42, mk(28'h700, 0, 1));
    bus.asid = 5;
    miss_fill(27'h43, mk(28'h501, 0, 0));
    flush(1, 0, 9'd5, 0);
    miss_fill(27'h40, mk(28'h500, 0, 0));
    miss_fill(27'h43, mk(28'h501, 0, 0));
    bus.asid = 6;
    hit(27'h41, mk(28'h600, 0, 0));
    hit(27'h42, mk(28'h700, 0, 1));
    bus.asid = 5;
    hit(27'h42, mk(28'h700, 0, 1));
    flush(0, 1, 0, 27'h41);
    bus.asid = 6;
    miss_fill(27'h41, mk(28'h601, 0, 0));
    bus.asid = 5;
    hit(27'h40, mk(28'h500, 0, 0));
    flush(0, 0, 0, 0);
    bus.asid = 6;
    miss_fill(27'h41, mk(28'h602, 0, 0));
    miss_fill(27'h42, mk(28'h701, 0, 0));
    bus.flush_v = 1;
    hit(27'h42, mk(28'h701, 0, 0));
    bus.flush_v = 0;
    miss_fill(27'h42, mk(28'h702, 0, 0));
    bus.asid = 5;
    lookup(27'h50, 1'b1, EW'(27'h50));
    bus.miss_ready = 1;
    step();
    bus.miss_ready = 0;
    flush(0, 0, 0, 0);
    bus.fill_v = 1;
    bus.fill_entry = mk(28'h900, 0, 0);
    step();
    bus.fill_v = 0;
    check("stale_idle", bus.r_ready, 1);
    miss_fill(27'h50, mk(28'h901, 0, 0));
    hit(27'h50, mk(28'h901, 0, 0));
    lookup(27'h51, 1'b1, EW'(27'h51));
    bus.miss_ready = 1;
    step();
    bus.miss_ready = 0;
    bus.fill_v = 1;
    bus.flush_v = 1;
    bus.fill_entry = mk(28'h900, 0, 0);
    step();
    bus.fill_v = 0;
    bus.flush_v = 0;
    check("stale_same_idle", bus.r_ready, 1);
    miss_fill(27'h51, mk(28'hA00, 0, 0));
    hit(27'h51, mk(28'hA00, 0, 0));
    bus.fill_v = 1;
    bus.flush_v = 1;
    bus.fill_entry = mk(28'hB00, 0, 0);
    step();
    bus.fill_v = 0;
    bus.flush_v = 0;
    hit(27'h51, mk(28'hB00, 0, 0));
    miss_fill(27'h50, mk(28'h902, 0, 0));
    lookup(27'h60, 1'b1, EW'(27'h60));
    check("abort_pre", bus.miss_v, 1);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_miss_v", bus.miss_v, 0);
    check("abort_ready", bus.r_ready, 1);
    step();
    reset_n = 1'b1;
    miss_fill(27'h51, mk(28'hC00, 0, 0));
    hit(27'h51, mk(28'hC00, 0, 0));
    repeat (3) step();
    check("queue_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
